ascii_result_tx: RTL and testbench

//  Turns a signed binary calculator result back into an ASCII character stream, one byte per transfer.
//  It is the transmit end of the ASCII byte interface: the calculator's parser consumes ASCII digits and

---
 rtl/ascii_result_tx_if.sv | 39 +++
 rtl/ascii_result_tx.sv | 180 ++++++++++++++++++
 tb/tb_ascii_result_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ascii_result_tx_if
// Description : Bundles the request side (start/value), the byte stream
//               handshake (char_out/char_valid/char_ready) and the status
//               flags (busy/done) of ascii_result_tx.
//               master : the producer of requests and consumer of bytes
//               slave  : the converter itself
// Signals     : start      request to convert value
//               value      signed value to transmit (WIDTH bits)
//               char_out   current ASCII byte
//               char_valid char_out holds a valid byte
//               char_ready sink accepts the byte on this clock edge
//               busy       conversion/emission in progress
//               done       one-cycle pulse after the terminator is accepted
// Revision    : 1.0 - initial release
// ============================================================================
interface ascii_result_tx_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, value, char_ready,
    input  char_out, char_valid, busy, done
  );

  modport slave (
    input  start, value, char_ready,
    output char_out, char_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ascii_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : ascii_result_tx
// Description : Converts a signed two's complement result into an ASCII
//               byte stream: optional '-', decimal digits MSD first, then a
//               terminator byte. One byte per valid/ready transfer.
// Ports       : clk  - clock, all state updates on the rising edge
//               rst  - asynchronous active-high reset
//               bus  - ascii_result_tx_if.slave (start/value request,
//                      char_out/char_valid/char_ready stream, busy/done)
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_result_tx #(
  parameter int         WIDTH      = 32,
  parameter int         MAX_DIGITS = 10,
  parameter logic [7:0] TERM       = 8'h0A
) (
  input logic               clk,
  input logic               rst,
  ascii_result_tx_if.slave  bus
);

  localparam int               c_CW       = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH-1:0] c_TEN      = WIDTH'(10);
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
  localparam logic [7:0]       c_MINUS    = 8'h2D;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_SIGN = 3'd2,
    S_DIGS = 3'd3,
    S_TERM = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_neg, w_neg_nxt;
  logic [WIDTH-1:0] r_mag, w_mag_nxt;
  logic [c_CW-1:0]  r_count, w_count_nxt;
  logic [c_CW-1:0]  r_idx, w_idx_nxt;
  logic [7:0]       r_char_out, w_char_nxt;
  logic             r_char_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       r_digits [MAX_DIGITS];

  logic             w_push;
  logic             w_xfer;
  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] w_quot;
  logic [3:0]       w_digit;

  function automatic logic [7:0] f_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Unsigned negation of the most-negative value yields exactly 2^(WIDTH-1),
  // which fits in WIDTH unsigned bits.
  assign w_abs   = bus.value[WIDTH-1] ? ((~bus.value) + c_ONE) : bus.value;
  assign w_quot  = r_mag / c_TEN;
  assign w_digit = 4'(r_mag % c_TEN);
  assign w_xfer  = r_char_valid & bus.char_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_neg_nxt   = r_neg;
    w_mag_nxt   = r_mag;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_char_nxt  = r_char_out;
    w_valid_nxt = r_char_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_push      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_neg_nxt   = bus.value[WIDTH-1];
          w_mag_nxt   = w_abs;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        // Digits are stored LSD first; the one pushed on the final cycle is
        // the MSD, so it can be presented directly without a buffer read.
        w_push      = 1'b1;
        w_mag_nxt   = w_quot;
        w_count_nxt = r_count + c_CNT_ONE;
        if (w_quot == '0) begin
          w_valid_nxt = 1'b1;
          if (r_neg) begin
            w_char_nxt  = c_MINUS;
            w_state_nxt = S_SIGN;
          end else begin
            w_char_nxt  = f_ascii(w_digit);
            w_idx_nxt   = r_count;
            w_state_nxt = S_DIGS;
          end
        end
      end
      S_SIGN: begin
        if (w_xfer) begin
          w_char_nxt  = f_ascii(r_digits[r_count - c_CNT_ONE]);
          w_idx_nxt   = r_count - c_CNT_ONE;
          w_state_nxt = S_DIGS;
        end
      end
      S_DIGS: begin
        // r_idx points at the digit currently on char_out; walk down to 0.
        if (w_xfer) begin
          if (r_idx == '0) begin
            w_char_nxt  = TERM;
            w_state_nxt = S_TERM;
          end else begin
            w_char_nxt = f_ascii(r_digits[r_idx - c_CNT_ONE]);
            w_idx_nxt  = r_idx - c_CNT_ONE;
          end
        end
      end
      S_TERM: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_neg        <= 1'b0;
      r_mag        <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_char_out   <= 8'h00;
      r_char_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_neg        <= w_neg_nxt;
      r_mag        <= w_mag_nxt;
      r_count      <= w_count_nxt;
      r_idx        <= w_idx_nxt;
      r_char_out   <= w_char_nxt;
      r_char_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        r_digits[i] <= 4'h0;
      end
    end else if (w_push) begin
      r_digits[r_count] <= w_digit;
    end
  end

  assign bus.char_out   = r_char_out;
  assign bus.char_valid = r_char_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ascii_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascii_result_tx
// Description : Self-checking bench for ascii_result_tx. Expected byte
//               strings come from $sformatf("%0d") of the signed value plus
//               the terminator; timing expectations from digit counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_result_tx;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascii_result_tx_if #(.WIDTH(WIDTH)) ifc ();

  ascii_result_tx #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (10),
    .TERM       (8'h0A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q [$];
  int         first_valid;
  int         done_cyc;
  int         stall_viol;
  int         gap_viol;
  bit         done_seen;

  function automatic string exp_str(input logic [31:0] v);
    return $sformatf("%0d", $signed(v));
  endfunction

  function automatic int exp_digits(input string s);
    logic [7:0] c0;
    c0 = s[0];
    return (c0 == 8'h2D) ? s.len() - 1 : s.len();
  endfunction

  function automatic int exp_neg(input string s);
    logic [7:0] c0;
    c0 = s[0];
    return (c0 == 8'h2D) ? 1 : 0;
  endfunction

  function automatic bit got_matches(input string s);
    logic [7:0] e;
    if (got_q.size() != s.len() + 1) return 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      e = s[i];
      if (got_q[i] !== e) return 1'b0;
    end
    return (got_q[s.len()] === 8'h0A);
  endfunction

  function automatic string got_hex();
    string r;
    r = "";
    foreach (got_q[i]) r = $sformatf("%s%02h ", r, got_q[i]);
    return r;
  endfunction

  function automatic string exp_hex(input string s);
    string      r;
    logic [7:0] e;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      e = s[i];
      r = $sformatf("%s%02h ", r, e);
    end
    return {r, "0a"};
  endfunction

  // Called at a negedge: the request is taken on the following posedge.
  task automatic kick(input logic [31:0] v);
    ifc.value = v;
    ifc.start = 1'b1;
  endtask

  // Runs one string to completion. mode 0: ready always 1, 1: toggling
  // 1,0,1,0..., 2: random. A start pulse with value 99 is driven at cycle
  // inject_at (0 = never). Returns at the negedge where done is seen.
  task automatic collect(input int mode, input int inject_at, input int max_cyc);
    bit         prev_stall;
    logic [7:0] prev_char;
    bit         started;
    bit         rdy;
    int         tog;
    prev_stall = 1'b0;
    prev_char  = 8'h00;
    started    = 1'b0;
    tog        = 0;
    got_q.delete();
    first_valid = -1;
    done_seen   = 1'b0;
    done_cyc    = -1;
    stall_viol  = 0;
    gap_viol    = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        ifc.start = 1'b1;
        ifc.value = 32'd99;
      end else begin
        ifc.start = 1'b0;
        ifc.value = $urandom();
      end
      if (ifc.done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = c;
        break;
      end
      if (prev_stall && (ifc.char_valid !== 1'b1 || ifc.char_out !== prev_char)) stall_viol++;
      if (started && ifc.char_valid !== 1'b1) gap_viol++;
      if (ifc.char_valid === 1'b1 && !started) begin
        started     = 1'b1;
        first_valid = c - 1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = (tog % 2 == 0); tog++; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ifc.char_ready = rdy;
      if (ifc.char_valid === 1'b1 && rdy) got_q.push_back(ifc.char_out);
      prev_stall = (ifc.char_valid === 1'b1) && !rdy;
      prev_char  = ifc.char_out;
    end
  endtask

  task automatic test_reset();
    total++; if (ifc.char_out !== 8'h00) begin bad++; $display("FAIL reset_char_out got=%h exp=00", ifc.char_out); end
    total++; if (ifc.char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifc.char_valid); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
  endtask

  // Full-rate string with exact latency and cycle-count checks.
  task automatic test_string(input logic [31:0] v);
    string s;
    int    n;
    int    ng;
    s  = exp_str(v);
    n  = exp_digits(s);
    ng = exp_neg(s);
    kick(v);
    collect(0, 0, 200);
    total++; if (!done_seen) begin bad++; $display("FAIL str_%s_done got=timeout exp=done", s); end
    total++; if (!got_matches(s)) begin bad++; $display("FAIL str_%s_bytes got=%s exp=%s", s, got_hex(), exp_hex(s)); end
    total++; if (first_valid != n) begin bad++; $display("FAIL str_%s_latency got=%0d exp=%0d", s, first_valid, n); end
    total++; if (done_cyc - 1 != 2 * n + ng + 1) begin bad++; $display("FAIL str_%s_cycles got=%0d exp=%0d", s, done_cyc - 1, 2 * n + ng + 1); end
    total++; if (ifc.busy !== 1'b0 || ifc.char_valid !== 1'b0) begin bad++; $display("FAIL str_%s_idle got=busy%b/valid%b exp=0/0", s, ifc.busy, ifc.char_valid); end
    @(negedge clk);
    total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL str_%s_done_width got=%b exp=0", s, ifc.done); end
  endtask

  task automatic test_basic();
    test_string(32'd0);
    test_string(32'd12345);
    test_string(-32'sd7);
    test_string(32'h8000_0000);
  endtask

  task automatic test_stall();
    int extra;
    kick(32'd42);
    collect(1, 3, 200);
    total++; if (!done_seen) begin bad++; $display("FAIL stall_done got=timeout exp=done"); end
    total++; if (!got_matches("42")) begin bad++; $display("FAIL stall_bytes got=%s exp=%s", got_hex(), exp_hex("42")); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_hold got=%0d violations exp=0", stall_viol); end
    total++; if (gap_viol != 0) begin bad++; $display("FAIL stall_gap got=%0d gaps exp=0", gap_viol); end
    extra = 0;
    ifc.char_ready = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (ifc.char_valid !== 1'b0 || ifc.busy !== 1'b0) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL stall_ignored_start got=%0d active cycles exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    kick(32'd12345);
    got_q.delete();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      ifc.start      = 1'b0;
      ifc.char_ready = 1'b1;
      if (ifc.char_valid === 1'b1) got_q.push_back(ifc.char_out);
      if (got_q.size() == 2) break;
    end
    total++; if (got_q.size() != 2 || got_q[0] !== 8'h31 || got_q[1] !== 8'h32) begin bad++; $display("FAIL rstmid_prefix got=%s exp=31 32", got_hex()); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (ifc.char_out !== 8'h00 || ifc.char_valid !== 1'b0) begin bad++; $display("FAIL rstmid_outputs got=%h/%b exp=00/0", ifc.char_out, ifc.char_valid); end
    total++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin bad++; $display("FAIL rstmid_status got=busy%b/done%b exp=0/0", ifc.busy, ifc.done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifc.char_valid !== 1'b0) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rstmid_abandon got=%0d valid cycles exp=0", extra); end
    kick(32'd9);
    collect(0, 0, 100);
    total++; if (!got_matches("9")) begin bad++; $display("FAIL rstmid_restart got=%s exp=%s", got_hex(), exp_hex("9")); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    kick(32'd25);
    collect(0, 0, 100);
    total++; if (!got_matches("25")) begin bad++; $display("FAIL b2b_first got=%s exp=%s", got_hex(), exp_hex("25")); end
    kick(-32'sd10);
    collect(0, 0, 100);
    total++; if (!done_seen || !got_matches("-10")) begin bad++; $display("FAIL b2b_second got=%s exp=%s", got_hex(), exp_hex("-10")); end
    total++; if (first_valid != 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", first_valid); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] v;
    string       s;
    for (int k = 0; k < 25; k++) begin
      v = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if (k == 0) v = 32'h7FFF_FFFF;
      s = exp_str(v);
      kick(v);
      collect(2, 0, 300);
      total++; if (!done_seen || !got_matches(s)) begin bad++; $display("FAIL rnd_%0d_bytes val=%s got=%s exp=%s", k, s, got_hex(), exp_hex(s)); end
      total++; if (first_valid != exp_digits(s)) begin bad++; $display("FAIL rnd_%0d_latency got=%0d exp=%0d", k, first_valid, exp_digits(s)); end
      total++; if (stall_viol != 0 || gap_viol != 0) begin bad++; $display("FAIL rnd_%0d_handshake got=hold%0d/gap%0d exp=0/0", k, stall_viol, gap_viol); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.value      = '0;
    ifc.char_ready = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
